muller_c_hs_driver: RTL and testbench

//  Synchronous-to-asynchronous front end for the Muller C-element pipeline.

---
 rtl/muller_c_hs_driver.sv | 142 ++++++++++++++
 tb/tb_muller_c_hs_driver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_hs_driver.sv
// Stream-to-four-phase bundled-data driver for a Muller C-element pipeline stage.
// Each accepted word is presented on data_o, then one req_o/ack_i handshake runs; ack_i is resynchronised here.
module muller_c_hs_driver #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  input  logic              err_clr,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        txn_count
);

  localparam int SW = (SETUP_CYC > 0) ? $clog2(SETUP_CYC + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, ERR} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic [7:0]             txn_q, txn_d;
  logic [SW-1:0]          setup_q, setup_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic                   ack_s;
  logic                   wait_expired;

  assign sync_d       = {sync_q[SYNC_STAGES-2:0], ack_i};
  assign ack_s        = sync_q[SYNC_STAGES-1];
  assign wait_expired = (wait_q == WW'(TIMEOUT - 1));

  assign in_ready    = (state_q == IDLE) && !ack_s;
  assign busy        = (state_q != IDLE);
  assign req_o       = req_q;
  assign data_o      = data_q;
  assign timeout_err = err_q;
  assign txn_count   = txn_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    txn_d   = txn_q;
    setup_d = setup_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d = in_data;
          wait_d = '0;
          if (SETUP_CYC > 0) begin
            // Loading SETUP_CYC (not SETUP_CYC-1) puts the req_o rise SETUP_CYC+1 edges after the accept.
            setup_d = SW'(SETUP_CYC);
            state_d = SETUP;
          end else begin
            req_d   = 1'b1;
            state_d = REQ_HI;
          end
        end
      end
      SETUP: begin
        if (setup_q == '0) begin
          req_d   = 1'b1;
          wait_d  = '0;
          state_d = REQ_HI;
        end else begin
          setup_d = setup_q - SW'(1);
        end
      end
      REQ_HI: begin
        // The awaited ack level is tested before the timeout so a same-edge completion wins.
        if (ack_s) begin
          req_d   = 1'b0;
          wait_d  = '0;
          state_d = REQ_LO;
        end else if (wait_expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          txn_d   = txn_q + 8'd1;
          state_d = IDLE;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ERR: begin
        req_d = 1'b0;
        if (err_clr && !ack_s) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      txn_q   <= 8'd0;
      setup_q <= '0;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
      setup_q <= setup_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_muller_c_hs_driver.sv
// Randomised bench for muller_c_hs_driver: a timestamp-based handshake model and a word scoreboard track the DUT every cycle.
module tb_muller_c_hs_driver;

  localparam int DATA_W    = 4;
  localparam int SYNC      = 2;
  localparam int SETUP_CYC = 1;
  localparam int TIMEOUT   = 255;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i = 1'b0;
  logic              err_clr = 1'b0;
  logic              busy;
  logic              timeout_err;
  logic [7:0]        txn_count;

  int errors = 0;
  int checks = 0;

  muller_c_hs_driver #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
    .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  initial forever #5 clock = ~clock;

  task automatic finish_sim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      if (errors >= 40) finish_sim();
    end
  endtask

  // Ack responder (acts at negedge+1): HOLD drives a fixed level, AUTO mirrors req_o after ack_dly negedges.
  typedef enum {A_HOLD, A_AUTO} amode_t;
  amode_t amode     = A_HOLD;
  bit     ack_force = 1'b0;
  bit     ack_rand  = 1'b0;
  int     ack_dly   = 2;
  int     ack_cnt   = 0;

  always @(negedge clock) begin
    #1;
    if (amode == A_HOLD) begin
      ack_i   = ack_force;
      ack_cnt = 0;
    end else if (req_o !== ack_i) begin
      if (ack_cnt + 1 >= ack_dly) begin
        ack_i   = req_o;
        ack_cnt = 0;
        if (ack_rand) ack_dly = $urandom_range(1, 4);
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Reference model (acts at negedge+3): protocol phases with edge timestamps, ack_s taken from an ack_i history.
  typedef enum {M_IDLE, M_SETUP, M_HI, M_LO, M_ERR} mphase_t;
  mphase_t           m_phase = M_IDLE;
  bit                m_req = 1'b0;
  bit                m_err = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_txn = 0;
  int                m_rise_at = 0;
  int                m_start = 0;
  int                n = 100;
  bit                hist [16];
  bit                prev_req = 1'b0;
  bit                as_now;
  logic [DATA_W-1:0] sb_word;
  logic [DATA_W-1:0] sent_q [$];

  always @(negedge clock) begin
    #3;
    n++;
    if (!reset_n) begin
      m_phase = M_IDLE; m_req = 1'b0; m_err = 1'b0; m_data = '0; m_txn = 0;
      prev_req = 1'b0;
      sent_q.delete();
      for (int i = 0; i < 16; i++) hist[i] = 1'b0;
    end else begin
      as_now = hist[(n - SYNC + 1) & 15];
      check("req_o", 32'(req_o), 32'(m_req));
      check("data_o", 32'(data_o), 32'(m_data));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
      check("txn_count", 32'(txn_count), 32'(m_txn % 256));
      check("busy", 32'(busy), 32'(m_phase != M_IDLE));
      check("in_ready", 32'(in_ready), 32'(m_phase == M_IDLE && !as_now));
      if (req_o && !prev_req) begin
        check("sb_pending", 32'(sent_q.size() != 0), 32'd1);
        if (sent_q.size() != 0) begin
          sb_word = sent_q.pop_front();
          check("sb_data", 32'(data_o), 32'(sb_word));
        end
      end
      prev_req = req_o;
      hist[(n + 1) & 15] = ack_i;
      case (m_phase)
        M_IDLE: if (in_valid && !as_now) begin
          m_data = in_data;
          m_start = n + 1;
          if (SETUP_CYC == 0) begin
            m_req = 1'b1; m_phase = M_HI;
          end else begin
            m_rise_at = n + 1 + SETUP_CYC + 1; m_phase = M_SETUP;
          end
        end
        M_SETUP: if (n + 1 == m_rise_at) begin
          m_req = 1'b1; m_phase = M_HI; m_start = n + 1;
        end
        M_HI: if (as_now) begin
          m_req = 1'b0; m_phase = M_LO; m_start = n + 1;
        end else if (n + 1 - m_start >= TIMEOUT) begin
          m_req = 1'b0; m_err = 1'b1; m_phase = M_ERR;
        end
        M_LO: if (!as_now) begin
          m_txn++; m_phase = M_IDLE;
        end else if (n + 1 - m_start >= TIMEOUT) begin
          m_err = 1'b1; m_phase = M_ERR;
        end
        M_ERR: if (err_clr && !as_now) begin
          m_err = 1'b0; m_phase = M_IDLE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Stimulus acts at negedge+2: after the responder, before the model samples.
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic send(input logic [DATA_W-1:0] w, input int budget);
    bit acc = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int c = 0; c < budget && !acc; c++) begin
      if (in_ready) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
    if (acc) sent_q.push_back(w);
  endtask

  task automatic wait_req(input logic v, input int budget, output int c);
    c = 0;
    while (req_o !== v && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (!(busy === 1'b0 && ack_i === 1'b0 && in_ready === 1'b1) && c < budget) begin
      tick();
      c++;
    end
    check("idle_reached", 32'(c < budget), 32'd1);
  endtask

  initial begin
    int c;
    // Reset values
    repeat (3) tick();
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_txn", 32'(txn_count), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #3 reset_n = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // Single word with fixed two-cycle ack response
    amode = A_AUTO; ack_rand = 1'b0; ack_dly = 2;
    in_data = 4'hA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sent_q.push_back(4'hA);
    check("t2_data", 32'(data_o), 32'hA);
    wait_req(1'b1, 20, c);
    check("t2_rise_lat", 32'(c), 32'(SETUP_CYC + 1));
    c = 0;
    while (ack_i !== 1'b1 && c < 20) begin tick(); c++; end
    wait_req(1'b0, 20, c);
    check("t2_fall_lat", 32'(c), 32'(SYNC + 1));
    wait_idle(100);
    check("t2_txn", 32'(txn_count), 32'd1);
    check("t2_data_hold", 32'(data_o), 32'hA);

    // Ordered stream 1..4
    for (int i = 1; i <= 4; i++) send(4'(i), 200);
    wait_idle(200);
    check("t3_txn", 32'(txn_count), 32'd5);

    // Random stream with random ack delays, gaps and stray err_clr outside ERR
    ack_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      err_clr = 1'($urandom_range(0, 1));
      send(4'($urandom_range(0, 15)), 200);
    end
    err_clr = 1'b0;
    wait_idle(300);
    check("rand_txn", 32'(txn_count), 32'd25);

    // Timeout waiting for ack rise
    amode = A_HOLD; ack_force = 1'b0;
    tick();
    send(4'h7, 20);
    wait_req(1'b1, 20, c);
    c = 0;
    while (!timeout_err && c < 400) begin tick(); c++; end
    check("to_hi_lat", 32'(c), 32'(TIMEOUT));
    check("to_hi_req", 32'(req_o), 32'd0);
    check("to_hi_ready", 32'(in_ready), 32'd0);
    check("to_hi_data", 32'(data_o), 32'h7);
    // err_clr while ack_s is high must not leave ERR
    ack_force = 1'b1;
    repeat (SYNC + 2) tick();
    err_clr = 1'b1;
    repeat (3) tick();
    check("err_hold_flag", 32'(timeout_err), 32'd1);
    check("err_hold_busy", 32'(busy), 32'd1);
    ack_force = 1'b0;
    c = 0;
    while (busy && c < 20) begin tick(); c++; end
    check("err_clear_flag", 32'(timeout_err), 32'd0);
    err_clr = 1'b0;

    // Timeout waiting for ack fall
    tick();
    send(4'h9, 20);
    wait_req(1'b1, 20, c);
    ack_force = 1'b1;
    wait_req(1'b0, 20, c);
    c = 0;
    while (!timeout_err && c < 400) begin tick(); c++; end
    check("to_lo_lat", 32'(c), 32'(TIMEOUT));
    ack_force = 1'b0;
    err_clr = 1'b1;
    c = 0;
    while (busy && c < 20) begin tick(); c++; end
    err_clr = 1'b0;
    check("to_lo_clear", 32'(timeout_err), 32'd0);
    check("to_lo_txn", 32'(txn_count), 32'd25);

    // Stale ack blocks acceptance until its low level is synchronised
    ack_force = 1'b1;
    repeat (SYNC + 2) tick();
    check("stale_ready", 32'(in_ready), 32'd0);
    in_data = 4'h5; in_valid = 1'b1;
    repeat (4) tick();
    check("stale_no_accept", 32'(busy), 32'd0);
    ack_force = 1'b0;
    c = 0;
    while (ack_i !== 1'b0 && c < 5) begin tick(); c++; end
    c = 0;
    while (!in_ready && c < 20) begin tick(); c++; end
    check("stale_release", 32'(c), 32'(SYNC));
    sent_q.push_back(4'h5);
    tick();
    in_valid = 1'b0;
    amode = A_AUTO; ack_rand = 1'b0; ack_dly = 1;
    wait_idle(100);
    check("stale_txn", 32'(txn_count), 32'd26);

    // Wrap the transaction counter through 256
    ack_rand = 1'b1;
    for (int i = 0; i < 230; i++) send(4'($urandom_range(0, 15)), 100);
    wait_idle(200);
    check("txn_wrap", 32'(txn_count), 32'd0);
    send(4'hC, 100);
    wait_idle(200);
    check("txn_after_wrap", 32'(txn_count), 32'd1);

    // Asynchronous reset mid-handshake drops the word
    amode = A_HOLD; ack_force = 1'b0;
    tick();
    send(4'h3, 20);
    wait_req(1'b1, 20, c);
    check("pre_reset_req", 32'(req_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_req", 32'(req_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    check("arst_txn", 32'(txn_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    @(posedge clock); #3 reset_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    finish_sim();
  end

endmodule
